// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test Avalon-MM master: writes a pattern over a word range, reads it back pipelined, compares.
// Optional feature macro TESTER_LFSR_EN selects a 16-bit LFSR data pattern instead of the address-derived one.
//
// state | meaning
// IDLE  | waiting for start; previous result held
// WRITE | writing one pattern word per accepted cycle
// READ  | issuing reads, at most MAX_PEND outstanding
// DRAIN | waiting for outstanding read data to return
// DONE  | run finished, result published
module sdram_pattern_tester #(
    parameter int unsigned     ADDR_W    = 24,
    parameter longint unsigned BASE_ADDR = 0,
    parameter longint unsigned NUM_WORDS = 16777216,
    parameter int unsigned     MAX_PEND  = 8,
    parameter logic [15:0]     SEED      = 16'hACE1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [15:0]       avm_writedata,
    output logic [1:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [15:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic [1:0]        test_result_export,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    generate
        if (ADDR_W < 16 || ADDR_W > 32) begin : g_bad_addr_w
            $error("sdram_pattern_tester: ADDR_W must be 16..32");
        end
        if (NUM_WORDS < 1 || (BASE_ADDR + NUM_WORDS) > (64'd1 << ADDR_W)) begin : g_bad_range
            $error("sdram_pattern_tester: BASE_ADDR/NUM_WORDS exceed the address space");
        end
        if (MAX_PEND < 1 || MAX_PEND > 255) begin : g_bad_pend
            $error("sdram_pattern_tester: MAX_PEND must be 1..255");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + NUM_WORDS - 1);
    localparam logic [7:0]        PEND_LIMIT = 8'(MAX_PEND);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t            state;
    logic [7:0]        pending;
    logic [7:0]        pending_next;
    logic              wr_accept;
    logic              rd_accept;
    logic              rd_valid;
    logic              at_last;
    logic              run_start;
    logic              read_entry;
    logic              err_any;
    logic [15:0]       first_data;
    logic [15:0]       next_data;
    logic [15:0]       exp_data;
    logic [ADDR_W-1:0] exp_addr;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cmp_valid;
    logic              cmp_mismatch;

    assign avm_byteenable = 2'b11;
    assign wr_accept      = avm_write & ~avm_waitrequest;
    assign rd_accept      = avm_read & ~avm_waitrequest;
    // Strobes with nothing outstanding are stale (e.g. data from before a reset).
    assign rd_valid       = avm_readdatavalid & (pending != 8'd0);
    assign pending_next   = pending + {7'd0, rd_accept} - {7'd0, rd_valid};
    assign at_last        = (avm_address == LAST_ADDR);
    assign run_start      = (state == IDLE) & start;
    assign read_entry     = (state == WRITE) & wr_accept & at_last;
    assign err_any        = (err_count != 16'd0) | (cmp_valid & cmp_mismatch);

`ifdef TESTER_LFSR_EN
    localparam logic [15:0] LFSR_SEED = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    logic [15:0] exp_lfsr;

    assign first_data = LFSR_SEED;
    assign next_data  = lfsr_step(avm_writedata);
    assign exp_data   = exp_lfsr;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            exp_lfsr <= LFSR_SEED;
        end else if (read_entry) begin
            exp_lfsr <= LFSR_SEED;
        end else if (rd_valid) begin
            exp_lfsr <= lfsr_step(exp_lfsr);
        end
    end
`else
    function automatic logic [15:0] addr_pattern(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ {a[ADDR_W-1 -: 8], a[ADDR_W-1 -: 8]} ^ SEED;
    endfunction

    assign first_data = addr_pattern(FIRST_ADDR);
    assign next_data  = addr_pattern(avm_address + ADDR_W'(1));
    assign exp_data   = addr_pattern(exp_addr);
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pending <= 8'd0;
        end else if (run_start) begin
            pending <= 8'd0;
        end else begin
            pending <= pending_next;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state              <= IDLE;
            avm_write          <= 1'b0;
            avm_read           <= 1'b0;
            avm_address        <= '0;
            avm_writedata      <= 16'd0;
            busy               <= 1'b0;
            test_result_export <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state              <= WRITE;
                        busy               <= 1'b1;
                        test_result_export <= 2'b01;
                        avm_write          <= 1'b1;
                        avm_address        <= FIRST_ADDR;
                        avm_writedata      <= first_data;
                    end
                end
                WRITE: begin
                    if (wr_accept) begin
                        if (at_last) begin
                            state       <= READ;
                            avm_write   <= 1'b0;
                            avm_read    <= 1'b1;
                            avm_address <= FIRST_ADDR;
                        end else begin
                            avm_address   <= avm_address + ADDR_W'(1);
                            avm_writedata <= next_data;
                        end
                    end
                end
                READ: begin
                    if (rd_accept && at_last) begin
                        state    <= DRAIN;
                        avm_read <= 1'b0;
                    end else begin
                        // A held read is never dropped here: pending cannot grow while stalled.
                        avm_read <= (pending_next < PEND_LIMIT);
                        if (rd_accept) begin
                            avm_address <= avm_address + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // err_any folds in the compare still sitting in the register this cycle.
                    if (pending == 8'd0) begin
                        state              <= DONE;
                        busy               <= 1'b0;
                        test_result_export <= err_any ? 2'b11 : 2'b10;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            exp_addr       <= FIRST_ADDR;
            cmp_addr       <= '0;
            cmp_valid      <= 1'b0;
            cmp_mismatch   <= 1'b0;
            err_count      <= 16'd0;
            first_err_addr <= '0;
        end else begin
            cmp_valid <= rd_valid;
            if (rd_valid) begin
                cmp_mismatch <= (avm_readdata != exp_data);
                cmp_addr     <= exp_addr;
                exp_addr     <= exp_addr + ADDR_W'(1);
            end
            if (run_start) begin
                exp_addr       <= FIRST_ADDR;
                err_count      <= 16'd0;
                first_err_addr <= '0;
            end else if (cmp_valid && cmp_mismatch) begin
                if (err_count == 16'd0) begin
                    first_err_addr <= cmp_addr;
                end
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: behavioural SDRAM slave with stalls, latency and corruption, plus a pattern model.
module tb_sdram_pattern_tester;

    localparam int unsigned TB_ADDR_W = 24;
    localparam int unsigned TB_BASE   = 0;
    localparam int unsigned TB_N      = 16;
    localparam int unsigned TB_MP     = 4;
    localparam logic [15:0] TB_SEED   = 16'hACE1;

    logic                 clk_clk = 1'b0;
    logic                 reset_reset;
    logic                 start;
    logic [TB_ADDR_W-1:0] avm_address;
    logic                 avm_write;
    logic                 avm_read;
    logic [15:0]          avm_writedata;
    logic [1:0]           avm_byteenable;
    logic                 avm_waitrequest;
    logic [15:0]          avm_readdata;
    logic                 avm_readdatavalid;
    logic                 busy;
    logic [1:0]           test_result_export;
    logic [15:0]          err_count;
    logic [TB_ADDR_W-1:0] first_err_addr;

    sdram_pattern_tester #(
        .ADDR_W(TB_ADDR_W), .BASE_ADDR(TB_BASE), .NUM_WORDS(TB_N),
        .MAX_PEND(TB_MP), .SEED(TB_SEED)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .busy(busy),
        .test_result_export(test_result_export), .err_count(err_count),
        .first_err_addr(first_err_addr)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct { logic [TB_ADDR_W-1:0] addr; logic [15:0] data; int unsigned cyc; } wr_t;
    typedef struct { int unsigned due; logic [TB_ADDR_W-1:0] addr; bit stale; } ret_t;

    int checks = 0;
    int errors = 0;

    // slave configuration and observation logs
    int unsigned          cyc = 0;
    int                   pol = 0;
    int unsigned          lat = 2;
    logic [15:0]          mem     [TB_N];
    logic [15:0]          corrupt [TB_N];
    wr_t                  wr_log[$];
    logic [TB_ADDR_W-1:0] rd_addr_log[$];
    ret_t                 ret_q[$];
    int                   out_cnt = 0, max_out = 0;
    int                   stab_viol = 0, pend_viol = 0, overlap = 0, oob = 0, res_run_bad = 0;
    int unsigned          last_rdv_cyc = 0, busy_fall_cyc = 0;
    bit                   prev_held = 1'b0, busy_prev = 1'b0;
    logic [43:0]          prev_sig = '0;
    ret_t                 s_e;
    logic                 s_w, s_acc_r, s_acc_w, s_got;

    function automatic logic [15:0] model_pattern(input int unsigned idx);
`ifdef TESTER_LFSR_EN
        int unsigned s, fb;
        s = (TB_SEED == 16'h0) ? 32'hACE1 : 32'(TB_SEED);
        for (int i = 0; i < int'(idx); i++) begin
            fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 32'h1;
            s  = (s >> 1) | (fb << 15);
        end
        return 16'(s);
`else
        int unsigned a;
        a = TB_BASE + idx;
        return 16'(a & 32'hFFFF) ^ 16'(((a >> 16) & 32'hFF) * 32'h101) ^ TB_SEED;
`endif
    endfunction

    function automatic int model_err_count();
        int n = 0;
        for (int i = 0; i < int'(TB_N); i++) if (corrupt[i] != 16'h0) n++;
        return n;
    endfunction

    function automatic logic [TB_ADDR_W-1:0] model_first_err();
        for (int i = 0; i < int'(TB_N); i++)
            if (corrupt[i] != 16'h0) return TB_ADDR_W'(TB_BASE + i);
        return '0;
    endfunction

    // Slave: decides waitrequest/readdatavalid at negedge for the following rising edge.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 16'h0;
        forever begin
            @(negedge clk_clk);
            cyc++;
            s_got = 1'b0;
            if (reset_reset) begin
                foreach (ret_q[i]) ret_q[i].stale = 1'b1;
                out_cnt           = 0;
                prev_held         = 1'b0;
                avm_readdatavalid = 1'b0;
                avm_waitrequest   = 1'b0;
            end else begin
                if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                    s_e = ret_q.pop_front();
                    avm_readdatavalid = 1'b1;
                    if (s_e.stale) begin
                        avm_readdata = 16'($urandom);
                    end else begin
                        avm_readdata = mem[s_e.addr[3:0]] ^ corrupt[s_e.addr[3:0]];
                        s_got        = 1'b1;
                        last_rdv_cyc = cyc;
                    end
                end else begin
                    avm_readdatavalid = 1'b0;
                    avm_readdata      = 16'($urandom);
                end
                case (pol)
                    1:       s_w = cyc[0];
                    2:       s_w = ($urandom_range(0, 2) == 0);
                    default: s_w = 1'b0;
                endcase
                avm_waitrequest = s_w;
                if (prev_held && ({avm_write, avm_read, avm_address, avm_writedata} !== prev_sig))
                    stab_viol++;
                if (avm_read && avm_write) overlap++;
                if (avm_read && out_cnt >= int'(TB_MP)) pend_viol++;
                s_acc_w = avm_write && !s_w;
                s_acc_r = avm_read && !s_w && !avm_write;
                if (s_acc_w) begin
                    wr_log.push_back('{avm_address, avm_writedata, cyc});
                    if (avm_address >= TB_ADDR_W'(TB_N)) oob++;
                    else mem[avm_address[3:0]] = avm_writedata;
                end
                if (s_acc_r) begin
                    rd_addr_log.push_back(avm_address);
                    ret_q.push_back('{cyc + lat, avm_address, 1'b0});
                end
                out_cnt = out_cnt + (s_acc_r ? 1 : 0) - (s_got ? 1 : 0);
                if (out_cnt > max_out) max_out = out_cnt;
                prev_held = (avm_write || avm_read) && s_w;
                prev_sig  = {avm_write, avm_read, avm_address, avm_writedata};
            end
            if (busy && test_result_export !== 2'b01) res_run_bad++;
            if (busy_prev && !busy) busy_fall_cyc = cyc;
            busy_prev = busy;
        end
    end

    task automatic clear_corrupt();
        for (int i = 0; i < int'(TB_N); i++) corrupt[i] = 16'h0;
    endtask

    task automatic do_run(input int p, input int unsigned l, input bit mid_start, output bit to);
        @(negedge clk_clk);
        pol = p; lat = l;
        wr_log.delete(); rd_addr_log.delete();
        stab_viol = 0; pend_viol = 0; overlap = 0; oob = 0; res_run_bad = 0; max_out = 0;
        last_rdv_cyc = 0; busy_fall_cyc = 0;
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            start = (mid_start && i == 10);
            if (!busy && i != 10) begin
                to = 1'b0;
                break;
            end
            @(negedge clk_clk);
        end
        start = 1'b0;
        @(negedge clk_clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, test_result_export, avm_read, avm_write, avm_address, avm_writedata, err_count, first_err_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%0b res=%0b rd=%0b wr=%0b addr=%h wd=%h err=%0d first=%h want all zero",
                     busy, test_result_export, avm_read, avm_write, avm_address, avm_writedata, err_count, first_err_addr);
        end
        checks++;
        if (avm_byteenable !== 2'b11) begin
            errors++; $display("FAIL byteenable got %b want 11", avm_byteenable);
        end
    endtask

    task automatic test_basic();
        bit to;
        int gaps, bad;
        clear_corrupt();
        do_run(0, 2, 1'b0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout busy never fell"); end
        checks++;
        if (wr_log.size() != TB_N) begin errors++; $display("FAIL basic_wr_count got %0d want %0d", wr_log.size(), TB_N); end
        gaps = 0;
        for (int i = 1; i < wr_log.size(); i++) if (wr_log[i].cyc != wr_log[0].cyc + i) gaps++;
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL basic_wr_back_to_back got %0d gaps want 0", gaps); end
        for (int i = 0; i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[i].addr !== TB_ADDR_W'(TB_BASE + i) || wr_log[i].data !== model_pattern(i)) begin
                errors++;
                $display("FAIL basic_wr_word%0d got addr=%h data=%h want addr=%h data=%h",
                         i, wr_log[i].addr, wr_log[i].data, TB_BASE + i, model_pattern(i));
            end
        end
`ifndef TESTER_LFSR_EN
        if (wr_log.size() > 5) begin
            checks++;
            if (wr_log[5].data !== 16'hACE4) begin errors++; $display("FAIL basic_addr5 got %h want ace4", wr_log[5].data); end
        end
`endif
        bad = 0;
        for (int i = 0; i < rd_addr_log.size(); i++) if (rd_addr_log[i] !== TB_ADDR_W'(TB_BASE + i)) bad++;
        checks++;
        if (rd_addr_log.size() != TB_N || bad != 0) begin
            errors++; $display("FAIL basic_rd_order got %0d reads %0d misordered want %0d in order", rd_addr_log.size(), bad, TB_N);
        end
        checks++;
        if ({test_result_export, err_count, first_err_addr} !== {2'b10, 16'd0, 24'd0}) begin
            errors++; $display("FAIL basic_result got res=%b err=%0d first=%h want res=10 err=0 first=0", test_result_export, err_count, first_err_addr);
        end
        checks++;
        if (busy_fall_cyc - last_rdv_cyc !== 2) begin
            errors++; $display("FAIL basic_done_latency got %0d want 2", busy_fall_cyc - last_rdv_cyc);
        end
        checks++;
        if (res_run_bad != 0 || oob != 0) begin
            errors++; $display("FAIL basic_running_status got %0d bad cycles %0d oob want 0", res_run_bad, oob);
        end
    endtask

    task automatic test_single_error();
        bit to;
        clear_corrupt();
        corrupt[9] = 16'h0001;
        do_run(0, 2, 1'b0, to);
        checks++;
        if (to || {test_result_export, err_count, first_err_addr} !== {2'b11, 16'd1, 24'd9}) begin
            errors++; $display("FAIL single_error got to=%0b res=%b err=%0d first=%h want res=11 err=1 first=9", to, test_result_export, err_count, first_err_addr);
        end
    endtask

    task automatic test_stall();
        bit to;
        clear_corrupt();
        do_run(1, 6, 1'b0, to);
        checks++;
        if (to || stab_viol != 0 || pend_viol != 0 || overlap != 0) begin
            errors++; $display("FAIL stall_protocol got to=%0b stab=%0d pend=%0d overlap=%0d want 0", to, stab_viol, pend_viol, overlap);
        end
        checks++;
        if (test_result_export !== 2'b10 || wr_log.size() != TB_N || rd_addr_log.size() != TB_N) begin
            errors++; $display("FAIL stall_result got res=%b wr=%0d rd=%0d want res=10 wr=rd=%0d", test_result_export, wr_log.size(), rd_addr_log.size(), TB_N);
        end
    endtask

    task automatic test_pend_limit();
        bit to;
        clear_corrupt();
        do_run(0, 9, 1'b0, to);
        checks++;
        if (to || max_out != int'(TB_MP) || pend_viol != 0 || test_result_export !== 2'b10) begin
            errors++; $display("FAIL pend_limit got to=%0b max_out=%0d viol=%0d res=%b want max_out=%0d viol=0 res=10", to, max_out, pend_viol, test_result_export, TB_MP);
        end
    endtask

    task automatic test_multi_error();
        bit to;
        clear_corrupt();
        corrupt[3] = 16'h8000; corrupt[7] = 16'h0F0F; corrupt[12] = 16'h0001;
        do_run(0, 3, 1'b1, to);
        checks++;
        if (to || {test_result_export, err_count, first_err_addr} !== {2'b11, 16'd3, 24'd3}) begin
            errors++; $display("FAIL multi_error got to=%0b res=%b err=%0d first=%h want res=11 err=3 first=3", to, test_result_export, err_count, first_err_addr);
        end
        checks++;
        if (wr_log.size() != TB_N || rd_addr_log.size() != TB_N) begin
            errors++; $display("FAIL mid_start_ignored got wr=%0d rd=%0d want %0d each", wr_log.size(), rd_addr_log.size(), TB_N);
        end
    endtask

    task automatic test_random();
        bit to;
        for (int it = 0; it < 4; it++) begin
            clear_corrupt();
            for (int a = 0; a < int'(TB_N); a++)
                if ($urandom_range(0, 3) == 0) corrupt[a] = 16'($urandom_range(1, 65535));
            do_run(2, $urandom_range(1, 8), 1'b0, to);
            checks++;
            if (to || int'(err_count) != model_err_count() || first_err_addr !== model_first_err() ||
                test_result_export !== ((model_err_count() == 0) ? 2'b10 : 2'b11)) begin
                errors++;
                $display("FAIL random%0d got to=%0b res=%b err=%0d first=%h want err=%0d first=%h",
                         it, to, test_result_export, err_count, first_err_addr, model_err_count(), model_first_err());
            end
            checks++;
            if (stab_viol != 0 || pend_viol != 0 || overlap != 0) begin
                errors++; $display("FAIL random%0d_protocol got stab=%0d pend=%0d overlap=%0d want 0", it, stab_viol, pend_viol, overlap);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        bit to, hit;
        clear_corrupt();
        @(negedge clk_clk);
        pol = 0; lat = 8;
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_cnt == int'(TB_MP)) begin hit = 1'b1; break; end
            @(negedge clk_clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL reset_mid_read_setup got out=%0d want %0d", out_cnt, TB_MP); end
        reset_reset = 1'b1;
        #1;
        checks++;
        if ({busy, test_result_export, avm_read, avm_write, avm_address, avm_writedata, err_count, first_err_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mid_read_values got busy=%0b res=%b rd=%0b wr=%0b addr=%h wd=%h want all zero",
                     busy, test_result_export, avm_read, avm_write, avm_address, avm_writedata);
        end
        @(negedge clk_clk);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ret_q.size() == 0) begin hit = 1'b1; break; end
            @(negedge clk_clk);
        end
        @(negedge clk_clk);
        @(negedge clk_clk);
        checks++;
        if (!hit || {busy, test_result_export, err_count, first_err_addr} !== '0) begin
            errors++; $display("FAIL stale_data_ignored got drained=%0b busy=%0b res=%b err=%0d want idle zero", hit, busy, test_result_export, err_count);
        end
        do_run(0, 2, 1'b0, to);
        checks++;
        if (to || {test_result_export, err_count} !== {2'b10, 16'd0} || rd_addr_log.size() != TB_N) begin
            errors++; $display("FAIL after_reset_run got to=%0b res=%b err=%0d rd=%0d want res=10 err=0", to, test_result_export, err_count, rd_addr_log.size());
        end
    endtask

`ifdef TESTER_LFSR_EN
    task automatic test_lfsr();
        bit to;
        logic [15:0] ref_seq [4];
        ref_seq = '{16'hACE1, 16'h5670, 16'hAB38, 16'h559C};
        clear_corrupt();
        do_run(0, 2, 1'b0, to);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_log.size() <= i || wr_log[i].data !== ref_seq[i]) begin
                errors++; $display("FAIL lfsr_word%0d got %h want %h", i, (wr_log.size() > i) ? wr_log[i].data : 16'hxxxx, ref_seq[i]);
            end
        end
        checks++;
        if (to || test_result_export !== 2'b10) begin errors++; $display("FAIL lfsr_result got %b want 10", test_result_export); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_reset = 1'b1;
        start       = 1'b0;
        clear_corrupt();
        for (int i = 0; i < int'(TB_N); i++) mem[i] = 16'h0;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        @(negedge clk_clk);
        test_reset();
        test_basic();
        test_single_error();
        test_stall();
        test_pend_limit();
        test_multi_error();
        test_random();
        test_reset_mid_read();
`ifdef TESTER_LFSR_EN
        test_lfsr();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
